// File: rtl/synth_param_bank.sv
// ============================================================================
// synth_param_bank : synthesizer parameter store, key/load editing, octave
// Revision: 1.0
// ============================================================================
`default_nettype none

module synth_param_bank #(
    parameter int          NUM_MODULES = 4,
    parameter int          NUM_PARAMS  = 16,
    parameter int          DATA_W      = 12,
    parameter int          MAX_VAL     = 4095,
    parameter int          DEFAULT_VAL = 0,
    parameter int          OCT_MAX     = 6,
    parameter int          OCT_DEFAULT = 4,
    parameter logic [7:0]  KEY_UP      = 8'h75,
    parameter logic [7:0]  KEY_DOWN    = 8'h72,
    parameter logic [7:0]  KEY_RIGHT   = 8'h74,
    parameter logic [7:0]  KEY_LEFT    = 8'h6B,
    // One spare bit so out-of-range module selects are representable and rejectable
    parameter int          MSEL_W      = $clog2(NUM_MODULES) + 1,
    parameter int          PSEL_W      = $clog2(NUM_PARAMS),
    parameter int          ADDR_W      = $clog2(NUM_MODULES * NUM_PARAMS)
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [MSEL_W-1:0]                        module_sel,
    input  logic [PSEL_W-1:0]                        param_sel,
    input  logic [DATA_W-1:0]                        wr_value,
    input  logic                                     load,
    input  logic                                     restore,
    input  logic                                     key_on,
    input  logic [7:0]                               key_code,
    output logic                                     busy,
    output logic [DATA_W-1:0]                        rd_data,
    output logic [NUM_MODULES*NUM_PARAMS*DATA_W-1:0] params_flat,
    output logic [2:0]                               global_octave,
    output logic                                     update_valid,
    output logic [ADDR_W-1:0]                        update_addr
);

    localparam int                C_N       = NUM_MODULES * NUM_PARAMS;
    localparam logic [DATA_W-1:0] C_MAX     = DATA_W'(MAX_VAL);
    localparam logic [DATA_W-1:0] C_DEF     = DATA_W'(DEFAULT_VAL);
    localparam logic [2:0]        C_OCT_MAX = 3'(OCT_MAX);
    localparam logic [2:0]        C_OCT_DEF = 3'(OCT_DEFAULT);
    localparam logic [ADDR_W-1:0] C_LAST    = ADDR_W'(C_N - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_mem [C_N];
    logic                r_load_d;
    logic                r_restore_d;
    logic                r_key_d;
    logic [ADDR_W-1:0]   r_sweep_idx;
    logic [2:0]          r_octave;
    logic                r_update_valid;
    logic [ADDR_W-1:0]   r_update_addr;

    logic                w_load_ev;
    logic                w_restore_ev;
    logic                w_key_ev;
    logic                w_sel_valid;
    logic [ADDR_W-1:0]   w_idx;
    logic [DATA_W-1:0]   w_cur;
    logic [DATA_W-1:0]   w_clamped;
    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [DATA_W-1:0]   w_wr_data;
    logic                w_pulse;

    assign w_load_ev    = load    & ~r_load_d;
    assign w_restore_ev = restore & ~r_restore_d;
    assign w_key_ev     = key_on  & ~r_key_d;

    assign w_sel_valid = (module_sel < MSEL_W'(NUM_MODULES));
    assign w_idx       = ADDR_W'(int'(module_sel) * NUM_PARAMS + int'(param_sel));
    assign w_cur       = r_mem[w_idx];
    assign w_clamped   = (wr_value > C_MAX) ? C_MAX : wr_value;

    assign rd_data       = w_sel_valid ? w_cur : '0;
    assign busy          = (r_state == ST_SWEEP);
    assign global_octave = r_octave;
    assign update_valid  = r_update_valid;
    assign update_addr   = r_update_addr;

    for (genvar gi = 0; gi < C_N; gi++) begin : g_flat
        assign params_flat[gi*DATA_W +: DATA_W] = r_mem[gi];
    end

    // History flops reset high so a level held through reset release is not an edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_load_d    <= 1'b1;
            r_restore_d <= 1'b1;
            r_key_d     <= 1'b1;
        end else begin
            r_load_d    <= load;
            r_restore_d <= restore;
            r_key_d     <= key_on;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_wr_en   = 1'b0;
        w_wr_addr = w_idx;
        w_wr_data = w_cur;
        w_pulse   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Load has priority over arrow edits on the same edge
                if (w_load_ev && w_sel_valid) begin
                    w_wr_en   = 1'b1;
                    w_wr_data = w_clamped;
                    w_pulse   = 1'b1;
                end else if (w_key_ev && w_sel_valid && key_code == KEY_RIGHT && w_cur < C_MAX) begin
                    w_wr_en   = 1'b1;
                    w_wr_data = w_cur + DATA_W'(1);
                    w_pulse   = 1'b1;
                end else if (w_key_ev && w_sel_valid && key_code == KEY_LEFT && w_cur != '0) begin
                    w_wr_en   = 1'b1;
                    w_wr_data = w_cur - DATA_W'(1);
                    w_pulse   = 1'b1;
                end
                if (w_restore_ev) begin
                    w_next = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_sweep_idx;
                w_wr_data = C_DEF;
                if (r_sweep_idx == C_LAST) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sweep_idx <= '0;
        end else if (r_state == ST_SWEEP && r_sweep_idx != C_LAST) begin
            r_sweep_idx <= r_sweep_idx + ADDR_W'(1);
        end else begin
            r_sweep_idx <= '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < C_N; i++) begin
                r_mem[i] <= C_DEF;
            end
        end else if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_update_valid <= 1'b0;
            r_update_addr  <= '0;
        end else begin
            r_update_valid <= w_pulse;
            if (w_pulse) begin
                r_update_addr <= w_idx;
            end
        end
    end

    // Octave keys act in every state, independent of load and sweep
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_octave <= C_OCT_DEF;
        end else if (w_key_ev) begin
            if (key_code == KEY_UP && r_octave < C_OCT_MAX) begin
                r_octave <= r_octave + 3'd1;
            end else if (key_code == KEY_DOWN && r_octave != 3'd0) begin
                r_octave <= r_octave - 3'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_synth_param_bank.sv
// ============================================================================
// tb_synth_param_bank : directed + random bench against a behavioural model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_synth_param_bank;

    localparam int NE = 64;
    localparam int MAXV = 4095;

    logic         clock;
    logic         reset;
    logic [2:0]   module_sel;
    logic [3:0]   param_sel;
    logic [11:0]  wr_value;
    logic         load;
    logic         restore;
    logic         key_on;
    logic [7:0]   key_code;
    logic         busy;
    logic [11:0]  rd_data;
    logic [767:0] params_flat;
    logic [2:0]   global_octave;
    logic         update_valid;
    logic [5:0]   update_addr;

    synth_param_bank dut (
        .clock         (clock),
        .reset         (reset),
        .module_sel    (module_sel),
        .param_sel     (param_sel),
        .wr_value      (wr_value),
        .load          (load),
        .restore       (restore),
        .key_on        (key_on),
        .key_code      (key_code),
        .busy          (busy),
        .rd_data       (rd_data),
        .params_flat   (params_flat),
        .global_octave (global_octave),
        .update_valid  (update_valid),
        .update_addr   (update_addr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int mem [NE];
    int oct;
    int sweep_left;
    int m_uv;
    int m_ua;
    bit p_load, p_restore, p_key;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NE; i++) mem[i] = 0;
        oct = 4;
        sweep_left = 0;
        m_uv = 0;
        m_ua = 0;
        p_load = 1'b1;
        p_restore = 1'b1;
        p_key = 1'b1;
    endtask

    task automatic model_edge();
        bit le, re, ke, valid;
        int idx;
        le = load && !p_load;
        re = restore && !p_restore;
        ke = key_on && !p_key;
        valid = (int'(module_sel) < 4);
        idx = int'(module_sel) * 16 + int'(param_sel);
        m_uv = 0;
        if (sweep_left > 0) begin
            mem[NE - sweep_left] = 0;
            sweep_left--;
        end else begin
            if (le && valid) begin
                mem[idx] = (int'(wr_value) > MAXV) ? MAXV : int'(wr_value);
                m_uv = 1; m_ua = idx;
            end else if (ke && valid && key_code == 8'h74 && mem[idx] < MAXV) begin
                mem[idx]++; m_uv = 1; m_ua = idx;
            end else if (ke && valid && key_code == 8'h6B && mem[idx] > 0) begin
                mem[idx]--; m_uv = 1; m_ua = idx;
            end
            if (re) sweep_left = NE;
        end
        if (ke && key_code == 8'h75 && oct < 6) oct++;
        else if (ke && key_code == 8'h72 && oct > 0) oct--;
        p_load = load;
        p_restore = restore;
        p_key = key_on;
    endtask

    task automatic check_all();
        int exp_rd;
        exp_rd = (int'(module_sel) < 4) ? mem[int'(module_sel) * 16 + int'(param_sel)] : 0;
        chk("busy", 32'(busy), 32'(sweep_left > 0));
        chk("octave", 32'(global_octave), 32'(oct));
        chk("update_valid", 32'(update_valid), 32'(m_uv));
        if (m_uv != 0) chk("update_addr", 32'(update_addr), 32'(m_ua));
        chk("rd_data", 32'(rd_data), 32'(exp_rd));
        for (int i = 0; i < NE; i++)
            chk($sformatf("entry%0d", i), 32'(params_flat[i*12 +: 12]), 32'(mem[i]));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic load_entry(input int m, input int p, input int v);
        module_sel = 3'(m); param_sel = 4'(p); wr_value = 12'(v);
        load = 1'b1; cycle();
        load = 1'b0; cycle();
    endtask

    task automatic key_press(input logic [7:0] code);
        key_code = code; key_on = 1'b1; cycle();
        key_on = 1'b0; cycle();
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            cycle();
            n++;
        end
        chk("wait_idle_timeout", 32'(busy), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;
        logic [7:0] codes [5];
        codes = '{8'h75, 8'h72, 8'h74, 8'h6B, 8'h1C};

        // Reset with key_on held high across release
        reset = 1'b1; module_sel = '0; param_sel = '0; wr_value = '0;
        load = 1'b0; restore = 1'b0; key_on = 1'b1; key_code = 8'h75;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check_all();
        repeat (3) cycle();
        chk("t1_octave", 32'(global_octave), 32'(4));
        chk("t1_busy", 32'(busy), 32'(0));
        key_on = 1'b0; cycle();

        // Load edge into entry 19, then hold load high
        module_sel = 3'd1; param_sel = 4'd3; wr_value = 12'h123; load = 1'b1;
        cycle();
        chk("t2_entry19", 32'(params_flat[19*12 +: 12]), 32'h123);
        chk("t2_pulse", 32'(update_valid), 32'(1));
        chk("t2_addr", 32'(update_addr), 32'd19);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (update_valid) pulses++;
        end
        chk("t2_no_repeat", 32'(pulses), 32'(0));
        load = 1'b0; cycle();

        // Saturation of arrow edits
        load_entry(1, 3, MAXV);
        key_code = 8'h74; key_on = 1'b1; cycle();
        chk("t3_right_sat_pulse", 32'(update_valid), 32'(0));
        chk("t3_right_sat_val", 32'(rd_data), 32'(MAXV));
        key_on = 1'b0; cycle();
        load_entry(1, 3, 0);
        key_code = 8'h6B; key_on = 1'b1; cycle();
        chk("t3_left_sat_pulse", 32'(update_valid), 32'(0));
        chk("t3_left_sat_val", 32'(rd_data), 32'(0));
        key_on = 1'b0; cycle();
        load_entry(1, 3, 5);
        key_code = 8'h6B; key_on = 1'b1; cycle();
        chk("t3_left_pulse", 32'(update_valid), 32'(1));
        chk("t3_left_val", 32'(rd_data), 32'(4));
        key_on = 1'b0; cycle();

        // Octave saturation both ways
        for (int k = 0; k < 8; k++) begin
            key_press(8'h75);
            chk("t4_up", 32'(global_octave), 32'((4 + k + 1 > 6) ? 6 : 4 + k + 1));
        end
        for (int k = 0; k < 8; k++) begin
            key_press(8'h72);
            chk("t4_down", 32'(global_octave), 32'((5 - k < 0) ? 0 : 5 - k));
        end

        // Randomized mix of loads, keys, invalid selects and simultaneous events
        for (int it = 0; it < 120; it++) begin
            module_sel = 3'($urandom_range(0, 4));
            param_sel  = 4'($urandom);
            wr_value   = 12'($urandom);
            case ($urandom_range(0, 3))
                0: begin load = 1'b1; cycle(); load = 1'b0; cycle(); end
                1: key_press(codes[$urandom_range(0, 4)]);
                2: begin
                    key_code = codes[$urandom_range(0, 4)];
                    load = 1'b1; key_on = 1'b1; cycle();
                    load = 1'b0; key_on = 1'b0; cycle();
                end
                default: cycle();
            endcase
        end

        // Restore sweep with load and octave key during it
        restore = 1'b1; cycle();
        chk("t5_busy_start", 32'(busy), 32'(1));
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (n == 1) restore = 1'b0;
            if (n == 10) begin
                module_sel = 3'd0; param_sel = 4'd1; wr_value = 12'd77; load = 1'b1;
            end
            if (n == 11) load = 1'b0;
            if (n == 20) begin key_code = 8'h75; key_on = 1'b1; end
            if (n == 21) key_on = 1'b0;
            cycle();
        end
        chk("t5_busy_cycles", 32'(n), 32'd64);
        pulses = 0;
        for (int i = 0; i < NE; i++) if (params_flat[i*12 +: 12] != 12'd0) pulses++;
        chk("t5_all_default", 32'(pulses), 32'(0));

        // Same-cycle load and RIGHT edit; invalid module select
        load_entry(0, 2, 3);
        wr_value = 12'd7; key_code = 8'h74; load = 1'b1; key_on = 1'b1;
        cycle();
        chk("t6_load_wins", 32'(rd_data), 32'd7);
        chk("t6_pulse", 32'(update_valid), 32'(1));
        chk("t6_addr", 32'(update_addr), 32'd2);
        load = 1'b0; key_on = 1'b0; cycle();
        chk("t6_single_pulse", 32'(update_valid), 32'(0));
        module_sel = 3'd4; param_sel = 4'd0; wr_value = 12'd55; load = 1'b1;
        cycle();
        chk("t6_invalid_pulse", 32'(update_valid), 32'(0));
        chk("t6_invalid_rd", 32'(rd_data), 32'(0));
        load = 1'b0; cycle();

        // Restore and load on the same edge: load commits, then sweep clears it
        module_sel = 3'd0; param_sel = 4'd5; wr_value = 12'd9;
        load = 1'b1; restore = 1'b1; cycle();
        chk("t7_load_commit", 32'(rd_data), 32'd9);
        chk("t7_busy", 32'(busy), 32'(1));
        load = 1'b0; restore = 1'b0;
        wait_idle(200);

        // Reset in the middle of a sweep
        load_entry(2, 7, 1234);
        restore = 1'b1; cycle();
        restore = 1'b0;
        repeat (5) cycle();
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("t8_abort_busy", 32'(busy), 32'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;
        cycle();
        chk("t8_octave", 32'(global_octave), 32'(4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
